pio_gpio_bank: RTL and testbench

Parametrised multi-bit bidirectional GPIO bank on an Avalon-MM slave port. It is the successor to the single-pin PIO. It adds a per-bit direction register, atomic set/clear of the output bits, synchronised input sampling, edge capture and a maskable interrupt. It sits on the system Avalon-MM interconnect and drives the WIDTH external pins.

---
 rtl/pio_gpio_pkg.sv | 36 +++
 rtl/pio_gpio_sync_edge.sv | 55 +++++
 rtl/pio_gpio_bank.sv | 115 +++++++++++
 tb/tb_pio_gpio_bank.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_gpio_pkg.sv
// Shared constants and helpers for the pio_gpio_bank GPIO block.
package pio_gpio_pkg;

   // Avalon-MM bus geometry
   localparam int unsigned ADDR_W = 3;
   localparam int unsigned DATA_W = 32;

   // Register word addresses
   localparam logic [ADDR_W-1:0] ADDR_DIR    = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] ADDR_DATA   = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_MASK   = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] ADDR_EDGE   = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] ADDR_OUTSET = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] ADDR_OUTCLR = ADDR_W'(5);

   // Edge-capture mode encodings
   localparam int unsigned EDGE_RISE = 0;
   localparam int unsigned EDGE_FALL = 1;
   localparam int unsigned EDGE_BOTH = 2;

   // Per-bit edge detect for the selected mode; unknown modes fall back to rising
   function automatic logic [DATA_W-1:0] edge_select(
      input int unsigned       mode,
      input logic [DATA_W-1:0] cur,
      input logic [DATA_W-1:0] prev
   );
      logic [DATA_W-1:0] res;
      case (mode)
         EDGE_FALL: res = ~cur & prev;
         EDGE_BOTH: res = cur ^ prev;
         default:   res = cur & ~prev;
      endcase
      return res;
   endfunction

endpackage : pio_gpio_pkg

// File: rtl/pio_gpio_sync_edge.sv
// Input synchroniser, previous-value flop, edge select and post-reset priming gate.
module pio_gpio_sync_edge
   import pio_gpio_pkg::*;
#(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned EDGE_TYPE   = EDGE_RISE
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] pin_in,
   output logic [WIDTH-1:0] in_sync,
   output logic [WIDTH-1:0] edge_pulse
);

   // Capture stays blocked until the chain and in_prev hold real pin history
   localparam int unsigned PRIME_CYC = SYNC_STAGES + 1;
   localparam int unsigned CNT_W     = $clog2(PRIME_CYC + 1);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
   logic [WIDTH-1:0]                  in_prev_q, in_prev_d;
   logic [CNT_W-1:0]                  prime_q, prime_d;
   logic                              primed;
   logic [WIDTH-1:0]                  edge_raw;

   assign in_sync = sync_q[SYNC_STAGES-1];
   assign primed  = (prime_q == CNT_W'(PRIME_CYC));

   // Next-state: shift chain, history flop and saturating priming counter
   always_comb begin
      sync_d    = {sync_q[SYNC_STAGES-2:0], pin_in};
      in_prev_d = in_sync;
      prime_d   = primed ? prime_q : prime_q + CNT_W'(1);
   end

   // Edge detect on the synchronised value, gated until primed
   always_comb begin
      edge_raw   = WIDTH'(edge_select(EDGE_TYPE, DATA_W'(in_sync), DATA_W'(in_prev_q)));
      edge_pulse = primed ? edge_raw : '0;
   end

   // State registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q    <= '0;
         in_prev_q <= '0;
         prime_q   <= '0;
      end else begin
         sync_q    <= sync_d;
         in_prev_q <= in_prev_d;
         prime_q   <= prime_d;
      end
   end

endmodule : pio_gpio_sync_edge

// File: rtl/pio_gpio_bank.sv
// Multi-bit bidirectional GPIO bank with Avalon-MM register access and edge interrupt.
module pio_gpio_bank
   import pio_gpio_pkg::*;
#(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned EDGE_TYPE   = EDGE_RISE
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] address,
   input  logic              write,
   input  logic              read,
   input  logic [DATA_W-1:0] writedata,
   output logic [DATA_W-1:0] readdata,
   output logic              irq,
   inout  wire  [WIDTH-1:0]  pio_pin
);

   logic [WIDTH-1:0]  dir_q, dir_d;
   logic [WIDTH-1:0]  data_out_q, data_out_d;
   logic [WIDTH-1:0]  mask_q, mask_d;
   logic [WIDTH-1:0]  edge_cap_q, edge_cap_d;
   logic [DATA_W-1:0] readdata_q, readdata_d;
   logic              irq_q, irq_d;

   logic [WIDTH-1:0]  wdata;
   logic [WIDTH-1:0]  edge_clr;
   logic [WIDTH-1:0]  in_sync;
   logic [WIDTH-1:0]  edge_pulse;

   assign wdata    = writedata[WIDTH-1:0];
   assign readdata = readdata_q;
   assign irq      = irq_q;

   // Upper write-data bits have no storage behind them
   if (WIDTH < DATA_W) begin : g_wd_unused
      logic unused_wd;
      assign unused_wd = ^writedata[DATA_W-1:WIDTH];
   end

   // Per-pin tri-state driver straight from the registers
   for (genvar i = 0; i < WIDTH; i++) begin : g_pin
      assign pio_pin[i] = dir_q[i] ? data_out_q[i] : 1'bz;
   end

   // Pin sampling and edge generation
   pio_gpio_sync_edge #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_TYPE   (EDGE_TYPE)
   ) u_sync_edge (
      .clk        (clk),
      .reset_n    (reset_n),
      .pin_in     (pio_pin),
      .in_sync    (in_sync),
      .edge_pulse (edge_pulse)
   );

   // Register writes, edge capture and interrupt next-state
   always_comb begin
      dir_d      = dir_q;
      data_out_d = data_out_q;
      mask_d     = mask_q;
      edge_clr   = '0;
      if (write) begin
         case (address)
            ADDR_DIR:    dir_d      = wdata;
            ADDR_DATA:   data_out_d = wdata;
            ADDR_MASK:   mask_d     = wdata;
            ADDR_EDGE:   edge_clr   = wdata;
            ADDR_OUTSET: data_out_d = data_out_q | wdata;
            ADDR_OUTCLR: data_out_d = data_out_q & ~wdata;
            default:     ;
         endcase
      end
      // A fresh edge beats a simultaneous write-1-to-clear
      edge_cap_d = (edge_cap_q & ~edge_clr) | edge_pulse;
      irq_d      = |(edge_cap_q & mask_q);
   end

   // Read mux on pre-write register values; holds between reads
   always_comb begin
      readdata_d = readdata_q;
      if (read) begin
         case (address)
            ADDR_DIR:  readdata_d = DATA_W'(dir_q);
            ADDR_DATA: readdata_d = DATA_W'(in_sync);
            ADDR_MASK: readdata_d = DATA_W'(mask_q);
            ADDR_EDGE: readdata_d = DATA_W'(edge_cap_q);
            default:   readdata_d = '0;
         endcase
      end
   end

   // State registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dir_q      <= '0;
         data_out_q <= '0;
         mask_q     <= '0;
         edge_cap_q <= '0;
         readdata_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         dir_q      <= dir_d;
         data_out_q <= data_out_d;
         mask_q     <= mask_d;
         edge_cap_q <= edge_cap_d;
         readdata_q <= readdata_d;
         irq_q      <= irq_d;
      end
   end

endmodule : pio_gpio_bank

// File: tb/tb_pio_gpio_bank.sv
// Self-checking bench for pio_gpio_bank: directed scenarios plus randomized traffic vs a reference model.
module tb_pio_gpio_bank;

   localparam int unsigned W  = 8;
   localparam int unsigned S  = 2;
   localparam int unsigned ET = 0;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  address;
   logic        write;
   logic        read;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;
   wire  [W-1:0] pio_pin;

   logic [W-1:0] tb_drv;
   logic [W-1:0] tb_en;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // Bench-side pin drivers for bits the DUT leaves as inputs
   for (genvar i = 0; i < W; i++) begin : g_tbpin
      assign pio_pin[i] = tb_en[i] ? tb_drv[i] : 1'bz;
   end

   pio_gpio_bank #(
      .WIDTH       (W),
      .SYNC_STAGES (S),
      .EDGE_TYPE   (ET)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .address   (address),
      .write     (write),
      .read      (read),
      .writedata (writedata),
      .readdata  (readdata),
      .irq       (irq),
      .pio_pin   (pio_pin)
   );

   // Reference model: registers plus a history of pin values seen at each edge
   logic [W-1:0]  m_dir, m_dout, m_mask, m_cap;
   logic [31:0]   m_rd;
   logic          m_irq;
   logic [W-1:0]  m_hist[$];
   int            m_age;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_dir  = '0;
      m_dout = '0;
      m_mask = '0;
      m_cap  = '0;
      m_rd   = '0;
      m_irq  = 1'b0;
      m_hist = {};
      for (int i = 0; i <= S; i++) m_hist.push_back('0);
      m_age  = 0;
   endtask

   // One clock edge of the behavioural model, using the bus inputs present at that edge
   task automatic model_edge();
      logic [W-1:0] pin_now, seen, seen_before, ev, wd, clr;
      pin_now     = (m_dir & m_dout) | (~m_dir & tb_drv);
      seen        = m_hist[S-1];   // pin value from S edges ago
      seen_before = m_hist[S];
      if (ET == 1)      ev = ~seen & seen_before;
      else if (ET == 2) ev = seen ^ seen_before;
      else              ev = seen & ~seen_before;
      if (m_age < S + 1) ev = '0;
      wd  = writedata[W-1:0];
      clr = '0;
      if (read) begin
         case (address)
            3'd0:    m_rd = 32'(m_dir);
            3'd1:    m_rd = 32'(seen);
            3'd2:    m_rd = 32'(m_mask);
            3'd3:    m_rd = 32'(m_cap);
            default: m_rd = 32'h0;
         endcase
      end
      m_irq = |(m_cap & m_mask);
      if (write) begin
         case (address)
            3'd0:    m_dir  = wd;
            3'd1:    m_dout = wd;
            3'd2:    m_mask = wd;
            3'd3:    clr    = wd;
            3'd4:    m_dout = m_dout | wd;
            3'd5:    m_dout = m_dout & ~wd;
            default: ;
         endcase
      end
      m_cap = (m_cap & ~clr) | ev;
      m_hist.push_front(pin_now);
      void'(m_hist.pop_back());
      if (m_age < S + 1) m_age++;
   endtask

   // Drive one bus cycle, advance the model, then check all outputs
   task automatic step(input logic we, input logic re, input logic [2:0] a, input logic [31:0] wd);
      logic [W-1:0] pin_exp;
      write     = we;
      read      = re;
      address   = a;
      writedata = wd;
      @(posedge clk);
      model_edge();
      #1;
      write = 1'b0;
      read  = 1'b0;
      tb_en = ~m_dir;
      #1;
      pin_exp = (m_dir & m_dout) | (~m_dir & tb_drv);
      chk("readdata", readdata, m_rd);
      chk("irq", 32'(irq), 32'(m_irq));
      chk("pins", 32'(pio_pin), 32'(pin_exp));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 32'h0);
   endtask

   // Assert reset away from a clock edge, check immediate effects, release on a falling edge
   task automatic do_reset();
      write   = 1'b0;
      read    = 1'b0;
      reset_n = 1'b0;
      model_reset();
      tb_en   = '1;
      #1;
      chk("rst_readdata", readdata, 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      chk("rst_pins_released", 32'(pio_pin), 32'(tb_drv));
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n   = 1'b0;
      address   = '0;
      write     = 1'b0;
      read      = 1'b0;
      writedata = '0;
      tb_drv    = '0;
      tb_en     = '1;
      #2;
      do_reset();

      // Reset state of DIR
      step(1'b0, 1'b1, 3'd0, 32'h0);
      chk("reset_dir", readdata, 32'h0);

      // Output drive and readback through the synchroniser
      step(1'b1, 1'b0, 3'd0, 32'hFF);
      step(1'b1, 1'b0, 3'd1, 32'hA5);
      chk("drive_a5", 32'(pio_pin), 32'hA5);
      idle(S);
      step(1'b0, 1'b1, 3'd1, 32'h0);
      chk("data_rd_a5", readdata, 32'h0000_00A5);

      // Atomic set/clear, then split direction
      step(1'b1, 1'b0, 3'd4, 32'h0F);
      step(1'b1, 1'b0, 3'd5, 32'h81);
      chk("setclr_pins", 32'(pio_pin), 32'h2E);
      tb_drv = 8'h60;
      step(1'b1, 1'b0, 3'd0, 32'h0F);
      chk("low_nibble", 32'(pio_pin[3:0]), 32'hE);
      idle(S);
      step(1'b0, 1'b1, 3'd1, 32'h0);
      chk("mixed_rd", readdata, 32'h6E);

      // Rising edge capture and interrupt on pin0
      tb_drv = 8'h00;
      step(1'b1, 1'b0, 3'd0, 32'h00);
      idle(4);
      step(1'b1, 1'b0, 3'd3, 32'hFF);
      step(1'b1, 1'b0, 3'd2, 32'h01);
      step(1'b0, 1'b1, 3'd3, 32'h0);
      chk("cap_clean", readdata, 32'h0);
      tb_drv = 8'h01;
      idle(3);
      chk("irq_not_yet", 32'(irq), 32'h0);
      idle(1);
      chk("irq_set", 32'(irq), 32'h1);
      step(1'b0, 1'b1, 3'd3, 32'h0);
      chk("cap_pin0", readdata, 32'h01);
      step(1'b1, 1'b0, 3'd3, 32'h01);
      idle(1);
      chk("irq_cleared", 32'(irq), 32'h0);
      tb_drv = 8'h00;
      idle(4);
      step(1'b0, 1'b1, 3'd3, 32'h0);
      chk("fall_ignored", readdata, 32'h0);

      // New edge on pin2 coinciding with its clear: the set wins
      tb_drv = 8'h04;
      idle(S);
      step(1'b1, 1'b0, 3'd3, 32'h04);
      step(1'b0, 1'b1, 3'd3, 32'h0);
      chk("set_beats_clr", readdata, 32'h04);

      // Pin held high through reset raises no edge
      tb_drv = 8'h08;
      do_reset();
      idle(6);
      step(1'b0, 1'b1, 3'd3, 32'h0);
      chk("prime_no_edge", readdata, 32'h0);

      // Reset in the middle of driving all pins high
      step(1'b1, 1'b0, 3'd0, 32'hFF);
      step(1'b1, 1'b0, 3'd1, 32'hFF);
      step(1'b0, 1'b1, 3'd0, 32'h0);
      tb_drv = 8'h00;
      do_reset();
      step(1'b1, 1'b1, 3'd6, 32'hFFFF_FFFF);
      step(1'b0, 1'b1, 3'd6, 32'h0);
      chk("addr6_rd", readdata, 32'h0);

      // Randomized traffic with occasional resets
      for (int n = 0; n < 1500; n++) begin
         logic [2:0] a;
         a = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) tb_drv = tb_drv ^ W'(1 << $urandom_range(0, W - 1));
         if (n % 500 == 499) do_reset();
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_pio_gpio_bank
